// File: rtl/fft_out_pkg.sv
// Shared definitions for the FFT output reorder buffer: default sizes and
// the read-side state type.
package fft_out_pkg;

    localparam int          DEF_WIDTH      = 18;
    localparam int          DEF_ADDR_W     = 11;
    localparam int unsigned DEF_MAX_POINTS = 1200;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2
    } rd_state_t;

endpackage

// File: rtl/fft_out_reorder_if.sv
// Sample bus between the FFT core, the reorder buffer and the downstream
// consumer. The slave modport is the reorder buffer's view.
interface fft_out_reorder_if
    import fft_out_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic                     in_en;
    logic signed [WIDTH-1:0]  in_re;
    logic signed [WIDTH-1:0]  in_im;
    logic [ADDR_W-1:0]        in_addr;
    logic                     in_last;
    logic [ADDR_W-1:0]        n_points;
    logic                     out_ready;
    logic                     out_valid;
    logic signed [WIDTH-1:0]  out_re;
    logic signed [WIDTH-1:0]  out_im;
    logic [ADDR_W-1:0]        out_index;
    logic                     out_last;
    logic                     busy;
    logic                     ovf_err;
    logic                     addr_err;

    modport slave (
        input  in_en, in_re, in_im, in_addr, in_last, n_points, out_ready,
        output out_valid, out_re, out_im, out_index, out_last, busy, ovf_err, addr_err
    );

    modport master (
        output in_en, in_re, in_im, in_addr, in_last, n_points, out_ready,
        input  out_valid, out_re, out_im, out_index, out_last, busy, ovf_err, addr_err
    );

endinterface

// File: rtl/reorder_bank_ram.sv
// Simple dual-port RAM holding both ping-pong banks; the bank bit is the
// address MSB. The read port only updates when re is high so the presented
// sample holds while the consumer stalls.
module reorder_bank_ram
    import fft_out_pkg::*;
#(
    parameter int DATA_W = 2 * DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

    // Write port: storage itself is never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: output register cleared on reset so no stale sample shows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_out_reorder.sv
// FFT output reorder buffer: accepts samples in any address order into a
// ping-pong bank pair and streams each completed frame in natural order
// over a valid/ready interface.
module fft_out_reorder
    import fft_out_pkg::*;
#(
    parameter int          WIDTH      = DEF_WIDTH,
    parameter int          ADDR_W     = DEF_ADDR_W,
    parameter int unsigned MAX_POINTS = DEF_MAX_POINTS
) (
    input  logic              clk,
    input  logic              rst,
    fft_out_reorder_if.slave  bus
);

    logic                   wb;
    logic                   rb;
    logic [1:0]             full;
    logic [ADDR_W-1:0]      n_bank [2];
    logic                   wr_active;
    logic                   ovf_err_q;
    logic                   addr_err_q;

    rd_state_t              state;
    rd_state_t              state_nxt;
    logic [ADDR_W-1:0]      rd_idx;
    logic [ADDR_W-1:0]      out_index_q;
    logic                   out_last_q;

    logic                   addr_bad;
    logic                   wr_ok;
    logic                   frame_end;
    logic                   ovf_hit;
    logic                   prime;
    logic                   advance;
    logic                   release_bank;
    logic                   ram_re;
    logic [ADDR_W:0]        ram_raddr;
    logic [2*WIDTH-1:0]     ram_rdata;
    logic [ADDR_W-1:0]      n_rd;

    // An address outside the current frame, or beyond the largest legal
    // transform, is rejected.
    assign addr_bad  = (bus.in_addr >= bus.n_points) || (32'(bus.in_addr) >= MAX_POINTS);
    assign ovf_hit   = bus.in_en && full[wb];
    assign wr_ok     = bus.in_en && !full[wb] && !addr_bad;
    assign frame_end = wr_ok && bus.in_last;
    assign n_rd      = n_bank[rb];

    reorder_bank_ram #(
        .DATA_W (2 * WIDTH),
        .ADDR_W (ADDR_W + 1)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr ({wb, bus.in_addr}),
        .wdata ({bus.in_re, bus.in_im}),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Read FSM next state and RAM read control.
    always_comb begin
        state_nxt    = state;
        prime        = 1'b0;
        advance      = 1'b0;
        release_bank = 1'b0;
        ram_re       = 1'b0;
        ram_raddr    = {rb, rd_idx};
        case (state)
            ST_IDLE: begin
                if (full[rb]) begin
                    state_nxt = ST_PRIME;
                end
            end
            ST_PRIME: begin
                prime     = 1'b1;
                ram_re    = 1'b1;
                ram_raddr = {rb, {ADDR_W{1'b0}}};
                state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (bus.out_ready) begin
                    if (out_last_q) begin
                        release_bank = 1'b1;
                        state_nxt    = full[~rb] ? ST_PRIME : ST_IDLE;
                    end else begin
                        advance = 1'b1;
                        ram_re  = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bank bookkeeping: write completion and read release may coincide and
    // always touch different banks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb         <= 1'b0;
            rb         <= 1'b0;
            full       <= 2'b00;
            wr_active  <= 1'b0;
            ovf_err_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            if (frame_end) begin
                full[wb] <= 1'b1;
                wb       <= ~wb;
            end
            if (release_bank) begin
                full[rb] <= 1'b0;
                rb       <= ~rb;
            end
            if (frame_end) begin
                wr_active <= 1'b0;
            end else if (wr_ok) begin
                wr_active <= 1'b1;
            end
            if (ovf_hit) begin
                ovf_err_q <= 1'b1;
            end
            if (bus.in_en && addr_bad) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    // Frame size latched per bank when its frame completes.
    always_ff @(posedge clk) begin
        if (frame_end) begin
            n_bank[wb] <= bus.n_points;
        end
    end

    // Read index and the index/last tag that travel with the RAM output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_idx      <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
        end else if (prime) begin
            rd_idx      <= ADDR_W'(1);
            out_index_q <= '0;
            out_last_q  <= (n_rd == ADDR_W'(1));
        end else if (advance) begin
            rd_idx      <= rd_idx + ADDR_W'(1);
            out_index_q <= rd_idx;
            out_last_q  <= (rd_idx == n_rd - ADDR_W'(1));
        end
    end

    assign bus.out_valid = (state == ST_STREAM);
    assign bus.out_re    = ram_rdata[2*WIDTH-1:WIDTH];
    assign bus.out_im    = ram_rdata[WIDTH-1:0];
    assign bus.out_index = out_index_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (|full) || (state != ST_IDLE) || wr_active;
    assign bus.ovf_err   = ovf_err_q;
    assign bus.addr_err  = addr_err_q;

endmodule

// File: doc/fft_out_reorder.md
FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

Interface
REQ-001 Parameter WIDTH, default 18, real/imag sample width.
REQ-002 Parameter ADDR_W, default 11, sample address width.
REQ-003 Parameter MAX_POINTS, default 1200, largest legal transform size.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_en  input  1  FFT output sample strobe (FFT do_en).
REQ-007 in_re, in_im  input  WIDTH each  FFT output sample, signed two's complement.
REQ-008 in_addr  input  ADDR_W  natural-order index of the current sample (FFT output address).
REQ-009 in_last  input  1  last sample of the frame (FFT Finish), valid only when in_en=1.
REQ-010 n_points  input  ADDR_W  transform size N of the frame being written, stable from first to last write.
REQ-011 out_ready  input  1  downstream accepts a sample.
REQ-012 out_valid  output  1  out_re/out_im/out_index hold a valid sample.
REQ-013 out_re, out_im  output  WIDTH each  sample in natural order.
REQ-014 out_index  output  ADDR_W  index of the presented sample, 0..N-1.
REQ-015 out_last  output  1  presented sample is index N-1.
REQ-016 busy  output  1  at least one bank holds an unread or partially written frame.
REQ-017 ovf_err, addr_err  output  1 each  sticky error flags.

Function
REQ-018 Two banks (ping-pong) of 2^ADDR_W words; write bank pointer wb and read bank pointer rb, both 0 after reset.
REQ-019 Write: when in_en=1, bank wb not full, and in_addr < n_points, sample is stored at [wb][in_addr]; writes in any address order are accepted.
REQ-020 When in_en=1 and in_addr >= n_points, the write is discarded and addr_err is set.
REQ-021 On an accepted write with in_last=1, n_points is latched as that bank's N, the bank is marked full, and wb toggles at the same clock edge.
REQ-022 When in_en=1 and bank wb is already full (both banks full), the sample is dropped and ovf_err is set; a frame-end on the same cycle in which rb is freed is still dropped.
REQ-023 Read FSM states: IDLE, PRIME, STREAM. IDLE->PRIME when bank rb is full. PRIME issues RAM read of index 0 and moves to STREAM. In STREAM out_valid=1.
REQ-024 RAM read latency is 1 cycle; out_valid rises 2 cycles after the clock edge that registers the last write of a frame.
REQ-025 Handshake: a sample transfers when out_valid and out_ready are both 1; otherwise out_re/out_im/out_index/out_last stay constant.
REQ-026 With out_ready held at 1, one sample per cycle with no bubbles; N samples in N consecutive cycles, indices 0,1,...,N-1.
REQ-027 On transfer of the out_last sample: bank rb is marked empty, rb toggles, and the FSM goes to PRIME if the other bank is full (exactly one bubble cycle), else IDLE.
REQ-028 Write-side frame completion and read-side bank release in the same cycle both take effect.
REQ-029 N=1 is legal: the single sample is presented with out_index=0 and out_last=1.
REQ-030 busy = any bank full, OR FSM not IDLE, OR at least one write accepted into bank wb since its last frame end.
REQ-031 ovf_err and addr_err clear only on reset.

Reset
REQ-032 rst asserted at any time immediately clears out_valid, out_last, out_index, out_re, out_im, busy, ovf_err, addr_err, wb, rb, the full flags, and the FSM (to IDLE).
REQ-033 RAM contents are not reset; no stale sample is presented after reset because the full flags are cleared.
REQ-034 A frame partially written or read when reset occurs is discarded entirely.

Structure
REQ-035 A shared package fft_out_pkg holds WIDTH, ADDR_W, MAX_POINTS, and the read FSM state type.
REQ-036 One sub-module, reorder_bank_ram, is a simple dual-port RAM: one write port, one synchronous read port, bank bit as address MSB, depth 2*2^ADDR_W, data width 2*WIDTH.

Verification
REQ-037 N=12, writes in bit-reversed-like order 0,6,3,9,1,7,4,10,2,8,5,11 with value = index, out_ready=1 -> out_valid 2 cycles after the last write; outputs 0..11 in order over 12 consecutive cycles; out_last on 11.
REQ-038 N=60, out_ready toggled 1,0,1,0 -> every index 0..59 is delivered exactly once; outputs stay stable on stall cycles.
REQ-039 Three back-to-back N=1200 frames with out_ready=0 -> frames 1 and 2 are stored; frame 3 sets ovf_err; then out_ready=1 -> 2400 samples (frames 1 then 2), one bubble between them.
REQ-040 N=24, one write with in_addr=30 -> addr_err=1, that write ignored, remaining 24 samples delivered intact.
REQ-041 rst pulsed after 500 of 1200 samples streamed -> out_valid=0 and busy=0 after the reset edge; a new N=2 frame then streams indices 0 and 1 correctly.
REQ-042 N=1 frame -> single output with out_index=0 and out_last=1; busy returns to 0 the cycle after the transfer.
